// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : router_pkg
//  Description : Shared router constants and flit link request/response types.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int ROUTER_FLIT_WIDTH = 34;
    localparam int ROUTER_N_VIRT_CHN = 2;
    // A single-VC router still carries a 1-bit vc_id, tied to zero.
    localparam int ROUTER_VC_W       = (ROUTER_N_VIRT_CHN > 1) ? $clog2(ROUTER_N_VIRT_CHN) : 1;

    typedef struct packed {
        logic [ROUTER_FLIT_WIDTH-1:0] fdata;
        logic                         valid;
        logic [ROUTER_VC_W-1:0]       vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

endpackage
`default_nettype wire

// File: rtl/output_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : output_vc_arbiter
//  Description : Transmit side of one router output port. Per-VC round-robin
//                arbitration with wormhole locking, then fixed VC priority
//                onto a single flit link. Combinational datapath; only the
//                per-VC lock/owner/round-robin pointer are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_vc_arbiter
    import router_pkg::*;
#(
    parameter int N_INPUTS   = 4,
    parameter int N_VIRT_CHN = ROUTER_N_VIRT_CHN,
    parameter int H_PRIORITY = 1,
    parameter int FLIT_WIDTH = ROUTER_FLIT_WIDTH
) (
    input  logic         clk,
    input  logic         arst,
    input  s_flit_req_t  fin_req_i  [N_INPUTS],
    output s_flit_resp_t fin_resp_o [N_INPUTS],
    output s_flit_req_t  fout_req_o,
    input  s_flit_resp_t fout_resp_i
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int VC_W  = ROUTER_VC_W;

    // Flit type field encodings (top two bits of fdata).
    localparam logic [1:0] c_HEAD      = 2'b00;
    localparam logic [1:0] c_BODY      = 2'b01;
    localparam logic [1:0] c_TAIL      = 2'b10;
    localparam logic [1:0] c_HEAD_ONLY = 2'b11;

    // Per-VC arbitration state.
    logic [N_VIRT_CHN-1:0] r_lock;
    logic [IDX_W-1:0]      r_owner  [N_VIRT_CHN];
    logic [IDX_W-1:0]      r_rr_ptr [N_VIRT_CHN];

    // Per-VC arbitration results.
    logic [N_INPUTS-1:0]   w_elig   [N_VIRT_CHN];
    logic [N_VIRT_CHN-1:0] w_vc_has;
    logic [IDX_W-1:0]      w_vc_win [N_VIRT_CHN];

    // Link selection.
    logic                  w_any;
    logic [VC_W-1:0]       w_sel_vc;
    logic [IDX_W-1:0]      w_sel_in;
    logic                  w_grant;
    logic                  w_xfer;
    logic [1:0]            w_sel_type;
    logic [IDX_W-1:0]      w_next_ptr;

    // Eligibility: unlocked VCs only accept packet starts; locked VCs only the owner.
    always_comb begin
        logic [1:0] w_type;
        w_type = 2'b00;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                w_type = fin_req_i[i].fdata[FLIT_WIDTH-1 -: 2];
                w_elig[v][i] = fin_req_i[i].valid
                            && (fin_req_i[i].vc_id == VC_W'(v))
                            && (r_lock[v] ? (r_owner[v] == IDX_W'(i))
                                          : ((w_type == c_HEAD) || (w_type == c_HEAD_ONLY)));
            end
        end
    end

    // Round-robin search per VC starting at rr_ptr; scanning offsets downward
    // and overwriting leaves the smallest offset (first after the pointer).
    always_comb begin
        int idx;
        idx = 0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            w_vc_has[v] = 1'b0;
            w_vc_win[v] = '0;
            for (int k = N_INPUTS - 1; k >= 0; k--) begin
                idx = int'(r_rr_ptr[v]) + k;
                if (idx >= N_INPUTS) begin
                    idx = idx - N_INPUTS;
                end
                if (w_elig[v][idx]) begin
                    w_vc_has[v] = 1'b1;
                    w_vc_win[v] = IDX_W'(idx);
                end
            end
        end
    end

    // Fixed VC priority for the link: last hit wins when H_PRIORITY, first hit otherwise.
    always_comb begin
        w_any    = 1'b0;
        w_sel_vc = '0;
        w_sel_in = '0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (w_vc_has[v] && ((H_PRIORITY != 0) || !w_any)) begin
                w_any    = 1'b1;
                w_sel_vc = VC_W'(v);
                w_sel_in = w_vc_win[v];
            end
        end
    end

    // Outputs are forced idle while reset is asserted, even with requests pending.
    assign w_grant    = w_any & ~arst;
    assign w_xfer     = w_grant & fout_resp_i.ready;
    assign w_sel_type = fin_req_i[w_sel_in].fdata[FLIT_WIDTH-1 -: 2];
    assign w_next_ptr = (w_sel_in == IDX_W'(N_INPUTS - 1)) ? '0 : (w_sel_in + IDX_W'(1));

    // Zero-latency datapath: mux the winner onto the link and route ready back to it alone.
    always_comb begin
        fout_req_o = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            fin_resp_o[i] = '0;
        end
        if (w_grant) begin
            fout_req_o.fdata           = fin_req_i[w_sel_in].fdata;
            fout_req_o.valid           = 1'b1;
            fout_req_o.vc_id           = w_sel_vc;
            fin_resp_o[w_sel_in].ready = fout_resp_i.ready;
        end
    end

    // Arbitration state advances only on an accepted flit, on the chosen VC.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_lock <= '0;
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                r_owner[v]  <= '0;
                r_rr_ptr[v] <= '0;
            end
        end else if (w_xfer) begin
            case (w_sel_type)
                c_HEAD: begin
                    r_lock[w_sel_vc]   <= 1'b1;
                    r_owner[w_sel_vc]  <= w_sel_in;
                    r_rr_ptr[w_sel_vc] <= w_next_ptr;
                end
                c_HEAD_ONLY: begin
                    r_rr_ptr[w_sel_vc] <= w_next_ptr;
                end
                c_TAIL: begin
                    // Pointer already moved past this input when the head won.
                    r_lock[w_sel_vc] <= 1'b0;
                end
                c_BODY: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_vc_arbiter
//  Description : Self-checking bench for output_vc_arbiter. Per-input flit
//                queues act as sources; a packet-level reference model picks
//                the expected link flit every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_vc_arbiter;
    import router_pkg::*;

    localparam int N = 4;
    localparam int V = 2;
    localparam int H = 1;

    typedef struct {
        logic [33:0] d;
        int          vc;
    } flit_t;

    logic         clk = 1'b0;
    logic         arst;
    s_flit_req_t  fin_req  [N];
    s_flit_resp_t fin_resp [N];
    s_flit_req_t  fout_req;
    s_flit_resp_t fout_resp;

    output_vc_arbiter #(
        .N_INPUTS   (N),
        .N_VIRT_CHN (V),
        .H_PRIORITY (H),
        .FLIT_WIDTH (34)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_req_i   (fin_req),
        .fin_resp_o  (fin_resp),
        .fout_req_o  (fout_req),
        .fout_resp_i (fout_resp)
    );

    always #5 clk = ~clk;

    flit_t       srcq [N][$];
    int          log_in[$];
    int          log_vc[$];
    int          m_lock [V];
    int          m_owner[V];
    int          m_rr   [V];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          seq      = 0;
    s_flit_req_t last_out;

    function automatic logic [33:0] mk(int t, int inp, int vc, int s);
        return {t[1:0], inp[7:0], vc[7:0], s[15:0]};
    endfunction

    task automatic push(int inp, int t, int vc);
        flit_t f;
        f.d  = mk(t, inp, vc, seq);
        f.vc = vc;
        seq++;
        srcq[inp].push_back(f);
    endtask

    // len 1 = head-only, otherwise head, len-2 bodies, tail
    task automatic push_pkt(int inp, int vc, int len);
        if (len == 1) begin
            push(inp, 3, vc);
        end else begin
            push(inp, 0, vc);
            for (int b = 0; b < len - 2; b++) push(inp, 1, vc);
            push(inp, 2, vc);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_lock[v] = 0; m_owner[v] = 0; m_rr[v] = 0;
        end
    endtask

    // Reference: which input would send which VC this cycle, from the queue fronts.
    task automatic model_eval(output bit ev, output int evc, output int ew);
        ev = 0; evc = 0; ew = 0;
        for (int v = 0; v < V; v++) begin
            int cand;
            cand = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                int t;
                i = (m_rr[v] + k) % N;
                if (cand < 0 && srcq[i].size() > 0 && srcq[i][0].vc == v) begin
                    t = int'(srcq[i][0].d[33:32]);
                    if (m_lock[v] != 0) begin
                        if (i == m_owner[v]) cand = i;
                    end else if (t == 0 || t == 3) begin
                        cand = i;
                    end
                end
            end
            if (cand >= 0 && (H != 0 || !ev)) begin
                ev = 1; evc = v; ew = cand;
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(string tag, int idx, int ein, int evc);
        int obs;
        obs = (idx < log_in.size()) ? (log_in[idx] * 16 + log_vc[idx]) : 'hFFFF;
        chk(tag, 64'(obs), 64'(ein * 16 + evc));
    endtask

    // One clock: drive queue fronts, compare at negedge, advance model, step to posedge+1.
    task automatic cycle();
        bit          ev;
        int          evc;
        int          ew;
        int          t;
        s_flit_req_t exp_req;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] act_rdy;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                fin_req[i].fdata = srcq[i][0].d;
                fin_req[i].valid = 1'b1;
                fin_req[i].vc_id = ROUTER_VC_W'(srcq[i][0].vc);
            end else begin
                fin_req[i] = '0;
            end
        end
        @(negedge clk);
        model_eval(ev, evc, ew);
        exp_req = '0;
        exp_rdy = '0;
        if (ev && !arst) begin
            exp_req.fdata = srcq[ew][0].d;
            exp_req.valid = 1'b1;
            exp_req.vc_id = ROUTER_VC_W'(evc);
            exp_rdy[ew]   = fout_resp.ready;
        end
        for (int i = 0; i < N; i++) act_rdy[i] = fin_resp[i].ready;
        last_out = fout_req;
        n_assert++;
        assert (fout_req === exp_req) else begin
            n_fail++;
            $error("FAIL link_req observed=%h expected=%h", fout_req, exp_req);
        end
        n_assert++;
        assert (act_rdy === exp_rdy) else begin
            n_fail++;
            $error("FAIL in_ready observed=%b expected=%b", act_rdy, exp_rdy);
        end
        if (arst) begin
            model_reset();
        end else if (ev && fout_resp.ready) begin
            log_in.push_back(ew);
            log_vc.push_back(evc);
            t = int'(srcq[ew][0].d[33:32]);
            if (t == 0) begin
                m_lock[evc] = 1; m_owner[evc] = ew; m_rr[evc] = (ew + 1) % N;
            end else if (t == 3) begin
                m_rr[evc] = (ew + 1) % N;
            end else if (t == 2) begin
                m_lock[evc] = 0;
            end
            void'(srcq[ew].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e3[6];
        int          cnt3;
        int          left;
        s_flit_req_t prev;

        e3 = '{2, 2, 2, 2, 0, 0};
        arst = 1'b1;
        fout_resp.ready = 1'b1;
        for (int i = 0; i < N; i++) fin_req[i] = '0;
        model_reset();

        // Reset holds the link idle even with a head waiting on input 1.
        push(1, 0, 0);
        push(1, 2, 0);
        repeat (3) cycle();
        chk("rst_valid", 64'(fout_req.valid), 64'(0));
        chk("rst_ready1", 64'(fin_resp[1].ready), 64'(0));
        arst = 1'b0;
        log_in.delete(); log_vc.delete();
        cycle();
        chk("rel_same_cycle", 64'(log_in.size()), 64'(1));
        cycle();
        chk_log("rel_head", 0, 1, 0);
        chk_log("rel_tail", 1, 1, 0);

        // Round-robin among head-only flits on VC1.
        log_in.delete(); log_vc.delete();
        push(0, 3, 1); push(1, 3, 1); push(2, 3, 1);
        repeat (3) cycle();
        chk_log("rr0", 0, 0, 1);
        chk_log("rr1", 1, 1, 1);
        chk_log("rr2", 2, 2, 1);
        push(0, 3, 1); push(3, 3, 1);
        repeat (2) cycle();
        chk_log("rr_wrap3", 3, 3, 1);
        chk_log("rr_wrap0", 4, 0, 1);

        // Wormhole lock on VC0: input 2 owns until tail, input 0 waits.
        log_in.delete(); log_vc.delete();
        push_pkt(2, 0, 4);
        push_pkt(0, 0, 2);
        repeat (6) cycle();
        for (int k = 0; k < 6; k++) chk_log("wormhole", k, e3[k], 0);

        // VC1 preempts an in-progress VC0 packet.
        log_in.delete(); log_vc.delete();
        push_pkt(0, 0, 3);
        cycle();
        push_pkt(1, 1, 2);
        repeat (4) cycle();
        chk_log("prio0", 0, 0, 0);
        chk_log("prio1", 1, 1, 1);
        chk_log("prio2", 2, 1, 1);
        chk_log("prio3", 3, 0, 0);
        chk_log("prio4", 4, 0, 0);

        // Backpressure mid-packet: link held stable, nothing accepted.
        log_in.delete(); log_vc.delete();
        push_pkt(3, 0, 4);
        cycle();
        fout_resp.ready = 1'b0;
        cycle();
        prev = last_out;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_stable", 64'(last_out), 64'(prev));
        end
        chk("bp_ready3", 64'(fin_resp[3].ready), 64'(0));
        chk("bp_no_xfer", 64'(log_in.size()), 64'(1));
        fout_resp.ready = 1'b1;
        repeat (3) cycle();
        chk("bp_resume", 64'(log_in.size()), 64'(4));

        // Orphan body on unlocked VC1 never wins; other traffic flows.
        log_in.delete(); log_vc.delete();
        push(3, 1, 1);
        push_pkt(0, 0, 3);
        push(2, 3, 1); push(2, 3, 1);
        push(1, 3, 1); push(1, 3, 1);
        repeat (20) cycle();
        cnt3 = 0;
        foreach (log_in[k]) if (log_in[k] == 3) cnt3++;
        chk("orphan_grants", 64'(cnt3), 64'(0));
        chk("orphan_others", 64'(log_in.size()), 64'(7));
        srcq[3].delete();

        // Reset mid-packet drops the VC1 lock held by input 0.
        push_pkt(0, 1, 3);
        cycle();
        arst = 1'b1;
        srcq[0].delete();
        push_pkt(1, 1, 2);
        repeat (2) cycle();
        arst = 1'b0;
        log_in.delete(); log_vc.delete();
        repeat (2) cycle();
        chk_log("arst_unlock0", 0, 1, 1);
        chk_log("arst_unlock1", 1, 1, 1);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 2) == 0)
                    push_pkt(i, int'($urandom_range(0, V - 1)), int'($urandom_range(1, 4)));
            end
            fout_resp.ready = ($urandom_range(0, 4) != 0);
            cycle();
        end
        fout_resp.ready = 1'b1;
        left = 0;
        for (int c = 0; c < 200; c++) begin
            left = 0;
            for (int i = 0; i < N; i++) left += srcq[i].size();
            if (left != 0) cycle();
        end
        left = 0;
        for (int i = 0; i < N; i++) left += srcq[i].size();
        chk("drain_empty", 64'(left), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
